// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the SAR ADC scan controller.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    LOAD,
    SHIFT
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_shift_out.sv
// Parallel-load, MSB-first serialiser that produces DataMark while its bits are valid.
module sar_shift_out
  import sar_adc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             mark_o,
  output logic             ser_o
);

  localparam int CNT_W = idx_width(WIDTH);

  logic [WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0] left_q;
  logic             mark_q;
  logic             ser_q;

  // The MSB goes straight onto ser_q at load, so sreg_q only holds the remaining bits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg_q <= '0;
      left_q <= '0;
      mark_q <= 1'b0;
      ser_q  <= 1'b0;
    end else if (load_i) begin
      sreg_q <= data_i << 1;
      ser_q  <= data_i[WIDTH-1];
      mark_q <= 1'b1;
      left_q <= CNT_W'(WIDTH - 1);
    end else if (shift_en_i && mark_q) begin
      if (left_q == '0) begin
        mark_q <= 1'b0;
        ser_q  <= 1'b0;
      end else begin
        ser_q  <= sreg_q[WIDTH-1];
        sreg_q <= sreg_q << 1;
        left_q <= left_q - 1'b1;
      end
    end
  end

  assign mark_o = mark_q;
  assign ser_o  = ser_q;

endmodule

// File: rtl/sar_adc_seq.sv
// SAR ADC controller with round-robin multi-channel scan sequencer.
// Define SAR_ADC_SERIAL_EN to add the SHIFT state and MSB-first serial result output.
module sar_adc_seq
  import sar_adc_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int CHANNELS      = 4,
  parameter  int SAMPLE_CYCLES = 2,
  localparam int CH_W          = idx_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                Start,
  input  logic                Compare,
  input  logic [CHANNELS-1:0] ch_mask,
  output logic [WIDTH-1:0]    B,
  output logic [CH_W-1:0]     ch_sel,
  output logic                sample,
  output logic                busy,
  output logic                LoadReg,
  output logic [WIDTH-1:0]    result,
  output logic [CH_W-1:0]     result_ch,
  output logic                DataMark,
  output logic                SerialOutput
);

  localparam int MAXC  = (SAMPLE_CYCLES > WIDTH) ? SAMPLE_CYCLES : WIDTH;
  localparam int CNT_W = idx_width(MAXC);

  state_t              state_q;
  logic [CHANNELS-1:0] mask_q;
  logic [CH_W-1:0]     ch_q, res_ch_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    b_q, res_q;
  logic                sample_q, busy_q, load_q;

  logic [WIDTH-1:0]    bit_k, code_d;
  logic [CH_W-1:0]     nxt_ch, first_ch, go_ch;
  logic                nxt_found, first_found, chan_done, go_smp, relatch;

  always_comb begin
    bit_k  = WIDTH'(1) << cnt_q;
    code_d = Compare ? b_q : (b_q & ~bit_k);

    // Descending scan leaves the lowest qualifying index in place.
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    first_found = 1'b0;
    first_ch    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
    end

`ifdef SAR_ADC_SERIAL_EN
    chan_done = (state_q == SHIFT) && (cnt_q == '0);
`else
    chan_done = (state_q == LOAD);
`endif

    go_smp  = 1'b0;
    go_ch   = first_ch;
    relatch = 1'b0;
    if ((state_q == IDLE) || (chan_done && !nxt_found)) begin
      go_smp  = Start && first_found;
      relatch = 1'b1;
    end else if (chan_done) begin
      go_smp = 1'b1;
      go_ch  = nxt_ch;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      res_q    <= '0;
      res_ch_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        SAMPLE: begin
          if (cnt_q == '0) begin
            state_q  <= CONVERT;
            sample_q <= 1'b0;
            cnt_q    <= CNT_W'(WIDTH - 1);
            b_q      <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CONVERT: begin
          if (cnt_q == '0) begin
            state_q  <= LOAD;
            load_q   <= 1'b1;
            res_q    <= code_d;
            res_ch_q <= ch_q;
            b_q      <= '0;
          end else begin
            b_q   <= code_d | (bit_k >> 1);
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef SAR_ADC_SERIAL_EN
        LOAD: begin
          state_q <= SHIFT;
          cnt_q   <= CNT_W'(WIDTH - 1);
        end
        SHIFT: cnt_q <= cnt_q - 1'b1;
`endif
        default: ;
      endcase

      // Scan decision overrides the per-state update at channel end and in IDLE.
      if ((state_q == IDLE) || chan_done) begin
        if (go_smp) begin
          state_q  <= SAMPLE;
          ch_q     <= go_ch;
          cnt_q    <= CNT_W'(SAMPLE_CYCLES - 1);
          sample_q <= 1'b1;
          busy_q   <= 1'b1;
          if (relatch) mask_q <= ch_mask;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

`ifdef SAR_ADC_SERIAL_EN
  sar_shift_out #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk       (clk),
    .clr       (clr),
    .load_i    (state_q == LOAD),
    .shift_en_i(state_q == SHIFT),
    .data_i    (res_q),
    .mark_o    (DataMark),
    .ser_o     (SerialOutput)
  );
`else
  assign DataMark     = 1'b0;
  assign SerialOutput = 1'b0;
`endif

  assign B         = b_q;
  assign ch_sel    = ch_q;
  assign sample    = sample_q;
  assign busy      = busy_q;
  assign LoadReg   = load_q;
  assign result    = res_q;
  assign result_ch = res_ch_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Scoreboard bench for sar_adc_seq: a comparator model per channel, expected results queued at stimulus.
module tb_sar_adc_seq;

  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int SC  = 2;
`ifdef SAR_ADC_SERIAL_EN
  localparam int PERIOD = SC + 2 * W + 1;
`else
  localparam int PERIOD = SC + W + 1;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       Start;
  logic       Compare;
  logic [3:0] ch_mask;
  logic [7:0] B, result;
  logic [1:0] ch_sel, result_ch;
  logic       sample, busy, LoadReg, DataMark, SerialOutput;

  logic [7:0] vin [NCH];

  int checks = 0;
  int errors = 0;
  int exp_code[$];
  int exp_ch[$];
  int exp_ser[$];

  int   cyc = 0;
  int   last_load = -1;
  bit   per_en = 1'b0;
  bit   prev_load = 1'b0;
  logic [7:0] acc = '0;
  int   nb = 0;

  sar_adc_seq #(
    .WIDTH        (W),
    .CHANNELS     (NCH),
    .SAMPLE_CYCLES(SC)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .Start       (Start),
    .Compare     (Compare),
    .ch_mask     (ch_mask),
    .B           (B),
    .ch_sel      (ch_sel),
    .sample      (sample),
    .busy        (busy),
    .LoadReg     (LoadReg),
    .result      (result),
    .result_ch   (result_ch),
    .DataMark    (DataMark),
    .SerialOutput(SerialOutput)
  );

  assign Compare = (B <= vin[ch_sel]);

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input int ch, input int code);
    exp_ch.push_back(ch);
    exp_code.push_back(code);
    exp_ser.push_back(code);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, maxc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_B"}, B, 0);
    check({tag, "_ch_sel"}, ch_sel, 0);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_LoadReg"}, LoadReg, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_result_ch"}, result_ch, 0);
    check({tag, "_DataMark"}, DataMark, 0);
    check({tag, "_SerialOutput"}, SerialOutput, 0);
  endtask

  // Monitor: pops the scoreboard on every LoadReg and checks the serial stream.
  always @(negedge clk) begin
    cyc++;
    if (!clr) begin
      if (LoadReg) begin
        if (exp_code.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got LoadReg ch=%0d result=0x%0h, expected none", result_ch, result);
        end else begin
          check("result", result, exp_code.pop_front());
          check("result_ch", result_ch, exp_ch.pop_front());
        end
        if (per_en) begin
          if (last_load >= 0) check("period", cyc - last_load, PERIOD);
          last_load = cyc;
        end
      end
`ifdef SAR_ADC_SERIAL_EN
      if (prev_load) check("datamark_rise", DataMark, 1);
      if (DataMark) begin
        acc = {acc[6:0], SerialOutput};
        nb++;
        if (nb == W) begin
          if (exp_ser.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_serial: got 0x%0h, expected none", acc);
          end else begin
            check("serial_word", acc, exp_ser.pop_front());
          end
          nb = 0;
        end
      end
`else
      if (LoadReg) begin
        check("datamark_tied", DataMark, 0);
        check("serial_tied", SerialOutput, 0);
      end
`endif
    end
    prev_load = LoadReg;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr     = 1'b1;
    Start   = 1'b0;
    ch_mask = 4'b0000;
    for (int i = 0; i < NCH; i++) vin[i] = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    clr = 1'b0;
    @(negedge clk);

    // Single channel, Vin=0xA5, with Start->sample latency.
    vin[0]  = 8'hA5;
    ch_mask = 4'b0001;
    expect_res(0, 8'hA5);
    Start = 1'b1;
    check("sample_before_edge", sample, 0);
    @(negedge clk);
    check("start_latency_sample", sample, 1);
    check("start_latency_busy", busy, 1);
    Start = 1'b0;
    wait_idle("a5_idle", 100);

    // Vin=0x00: trial codes walk one bit down from the MSB.
    vin[0] = 8'h00;
    expect_res(0, 8'h00);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("b_during_sample", B, 0);
    repeat (SC - 1) @(negedge clk);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("b_trial_zero", B, 8'h80 >> k);
    end
    wait_idle("zero_idle", 100);

    // Vin=0xFF.
    vin[0] = 8'hFF;
    expect_res(0, 8'hFF);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_idle("ff_idle", 100);

    // Mask 1010 with Start held: ch1,ch3 repeat, fixed period; drop Start in scan two.
    vin[1]    = 8'h11;
    vin[3]    = 8'h33;
    ch_mask   = 4'b1010;
    last_load = -1;
    per_en    = 1'b1;
    expect_res(1, 8'h11);
    expect_res(3, 8'h33);
    expect_res(1, 8'h11);
    expect_res(3, 8'h33);
    Start = 1'b1;
    begin
      int seen = 0;
      int n = 0;
      while (seen < 3 && n < 300) begin
        @(negedge clk);
        n++;
        if (LoadReg) seen++;
      end
      check("loads_seen", seen, 3);
    end
    Start = 1'b0;
    wait_idle("scan2_idle", 200);
    per_en = 1'b0;

    // Empty mask with Start high never starts a scan.
    ch_mask = 4'b0000;
    Start   = 1'b1;
    repeat (20) @(negedge clk);
    check("mask0_busy", busy, 0);
    Start = 1'b0;
    @(negedge clk);

    // Full mask, Start pulsed; a mid-scan mask change must be ignored.
    vin[0]  = 8'h00;
    vin[1]  = 8'h5A;
    vin[2]  = 8'hC3;
    vin[3]  = 8'hFF;
    ch_mask = 4'b1111;
    expect_res(0, 8'h00);
    expect_res(1, 8'h5A);
    expect_res(2, 8'hC3);
    expect_res(3, 8'hFF);
    Start = 1'b1;
    @(negedge clk);
    Start   = 1'b0;
    ch_mask = 4'b0001;
    wait_idle("full_scan_idle", 300);
    check("full_scan_last_ch", result_ch, 3);

    // clr in the middle of CONVERT, then a clean conversion.
    vin[0] = 8'h77;
    Start  = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (SC + 1) @(negedge clk);
    clr = 1'b1;
    #1;
    check_all_zero("clr_mid");
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("clr_stays_idle", busy, 0);
    vin[0]  = 8'h3C;
    ch_mask = 4'b0001;
    expect_res(0, 8'h3C);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_idle("after_clr_idle", 100);
    repeat (3) @(negedge clk);

    check("sb_results_left", exp_code.size(), 0);
`ifdef SAR_ADC_SERIAL_EN
    check("sb_serial_left", exp_ser.size(), 0);
    check("serial_partial_bits", nb, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_seq.md
# sar_adc_seq

Parametrised successive-approximation ADC controller with a multi-channel scan sequencer. It drives the comparator DAC code, muxes and samples up to CHANNELS analog inputs in round-robin order, and resolves WIDTH bits per channel. Each result is presented in parallel with a load strobe and, optionally, shifted out serially MSB-first. It replaces the fixed 8-bit single-channel controller in the ADC front end.

## Interface
- WIDTH, 8, conversion resolution in bits (2..16)
- CHANNELS, 4, number of analog channels (1..16)
- SAMPLE_CYCLES, 2, track/hold cycles per channel (>=1)
- CH_W, $clog2(CHANNELS) (min 1), channel index width (derived, not overridden)

- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset; asynchronous, active-high
- Start  in  1  level; high requests scanning, sampled in IDLE and at end of each scan
- Compare  in  1  comparator result; 1 = Vin >= DAC code B
- ch_mask  in  CHANNELS  channel enable mask, latched at scan start
- B  out  WIDTH  DAC trial code
- ch_sel  out  CH_W  analog mux select
- sample  out  1  track/hold enable
- busy  out  1  high whenever not IDLE
- LoadReg  out  1  one-cycle strobe, result/result_ch valid
- result  out  WIDTH  last converted code
- result_ch  out  CH_W  channel of result
- DataMark  out  1  high while SerialOutput carries a valid bit
- SerialOutput  out  1  serial result, MSB first

## Operation
- States: IDLE, SAMPLE, CONVERT, LOAD, SHIFT.
- IDLE: Start=1 and ch_mask!=0 -> latch mask, ch_sel = lowest enabled channel, go SAMPLE. ch_mask=0 -> stay IDLE.
- SAMPLE: sample=1 for SAMPLE_CYCLES cycles; B=0; then CONVERT with bit index k=WIDTH-1.
- CONVERT: B = code | (1<<k). On the clock edge ending the cycle, bit k kept iff Compare=1, else cleared. k decrements; after k=0 go LOAD. Exactly WIDTH cycles.
- LOAD: LoadReg=1 for one cycle; result and result_ch register final code/channel on that edge; hold until next LOAD. Go SHIFT.
- SHIFT: WIDTH cycles, cycle j drives SerialOutput=result[WIDTH-1-j], DataMark=1.
- Last SHIFT cycle: next enabled channel above current in latched mask -> SAMPLE on it; none -> scan done: Start=1 re-latches ch_mask, restarts from lowest enabled channel (IDLE if new mask is 0); Start=0 -> IDLE.
- Start falling mid-scan does not abort; scan completes. ch_mask changes mid-scan are ignored.
- Compare is ignored outside CONVERT.

## Timing
- Reset values: B=0, ch_sel=0, sample=0, busy=0, LoadReg=0, result=0, result_ch=0, DataMark=0, SerialOutput=0; state IDLE.
- clr asserted mid-operation clears all state immediately; no partial LoadReg.
- Start->sample latency: 1 cycle (Start sampled at edge, SAMPLE begins next cycle).
- Per-channel period: SAMPLE_CYCLES + WIDTH + 1 + WIDTH cycles (serial enabled); no idle gap between channels.
- LoadReg occurs SAMPLE_CYCLES+WIDTH cycles after entering SAMPLE; DataMark rises the cycle after LoadReg.
- Compare must settle within one cycle of B changing.

## Configuration
- SAR_ADC_SERIAL_EN defined: SHIFT state and serial shifter present as above.
- Undefined: SHIFT omitted; channel/scan decision made in LOAD; DataMark and SerialOutput tied 0; per-channel period SAMPLE_CYCLES+WIDTH+1.

## Structure
- Package sar_adc_pkg: state enum (IDLE, SAMPLE, CONVERT, LOAD, SHIFT), channel-width helper function.
- Sub-module sar_shift_out: parallel-load, MSB-first shift register with load, shift-enable, DataMark generation; instantiated only under SAR_ADC_SERIAL_EN.
- Next-channel priority search (lowest set bit above current index) stays in top level.

## Test plan
- WIDTH=8, CH0 only, Vin=0xA5 model (Compare = B<=0xA5): result=0xA5, result_ch=0, SerialOutput 1,0,1,0,0,1,0,1 with DataMark high 8 cycles.
- Extremes: Vin=0xFF -> result 0xFF; Vin=0x00 -> result 0x00; B sequence for 0x00 is 0x80,0x40,...,0x01.
- ch_mask=4'b1010, Start held, Vin per channel 0x11/0x33: LoadReg order ch1,ch3,ch1,ch3..., period 19 cycles (SAMPLE_CYCLES=2), results match.
- ch_mask=0 with Start=1: busy stays 0, no LoadReg; Start dropped mid-scan on mask 4'b1111: ch0..ch3 complete, then IDLE.
- clr pulsed mid-CONVERT: all outputs 0 same cycle, IDLE; new Start yields correct conversion.
- Build without SAR_ADC_SERIAL_EN: DataMark/SerialOutput stay 0, per-channel period 11 cycles, results unchanged.
